// File: rtl/ahb_slave_arbiter_pkg.sv
// Shared AHB types and helpers for the per-slave arbiter.
package ahb_slave_arbiter_pkg;

  // AHB transfer type encoding (HTRANS).
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_type;

  // AHB burst type encoding (HBURST).
  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_type;

  // Arbiter ownership state.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN   = 2'd1,
    ARB_BURST = 2'd2
  } arb_state_e;

  // Width of the remaining-beats counter (enough for a 16-beat burst).
  localparam int BEATS_W = 4;

  // Number of beats in a burst; 0 marks undefined-length INCR.
  function automatic logic [4:0] burst_len(input hburst_type b);
    logic [4:0] len;
    case (b)
      SINGLE:         len = 5'd1;
      INCR:           len = 5'd0;
      WRAP4,  INCR4:  len = 5'd4;
      WRAP8,  INCR8:  len = 5'd8;
      WRAP16, INCR16: len = 5'd16;
      default:        len = 5'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin search: first requester above ptr, wrapping.
module ahb_rr_picker
  import ahb_slave_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] win_idx,
  output logic          any
);

  logic          found;
  logic [IW-1:0] cand;

  // Scan ptr+1 .. ptr+N (mod N); the last candidate is ptr itself, so the
  // previous winner only wins again when nobody else is asking.
  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        win[cand] = 1'b1;
        win_idx   = cand;
        found     = 1'b1;
      end
    end
    any = found;
  end

endmodule

// File: rtl/ahb_slave_arbiter.sv
// Per-slave AHB arbiter: round-robin grant, burst locking, data-phase owner.
module ahb_slave_arbiter
  import ahb_slave_arbiter_pkg::*;
#(
  parameter int MASTER_NUM = 4,
  parameter int MIDX_W     = $clog2(MASTER_NUM)
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic [MASTER_NUM-1:0] hreq,
  input  htrans_type            htrans [MASTER_NUM],
  input  hburst_type            hburst [MASTER_NUM],
  input  logic                  hready,
  output logic [MASTER_NUM-1:0] hgrant,
  output logic                  hsel,
  output logic [MIDX_W-1:0]     haddr_owner,
  output logic [MIDX_W-1:0]     hdata_owner,
  output logic                  hdata_valid
);

  arb_state_e            state_q, state_d;
  logic [MASTER_NUM-1:0] grant_q, grant_d;
  logic [MIDX_W-1:0]     owner_q, owner_d;
  logic [MIDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [BEATS_W-1:0]    beats_left_q, beats_left_d;
  logic [MIDX_W-1:0]     data_owner_q, data_owner_d;
  logic                  data_valid_q, data_valid_d;

  logic [MASTER_NUM-1:0] pick_win;
  logic [MIDX_W-1:0]     pick_idx;
  logic                  pick_any;

  logic                  own_req;
  htrans_type            own_trans;
  logic [4:0]            own_len;
  logic                  own_addr;
  logic                  rearb;

  ahb_rr_picker #(
    .N  (MASTER_NUM),
    .IW (MIDX_W)
  ) u_picker (
    .req     (hreq),
    .ptr     (rr_ptr_q),
    .win     (pick_win),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  // The current address-phase owner's live signals.
  assign own_req   = hreq[owner_q];
  assign own_trans = htrans[owner_q];
  assign own_len   = burst_len(hburst[owner_q]);
  assign own_addr  = (own_trans == NONSEQ) || (own_trans == SEQ);

  // State register; reset wins over hready and drops any ownership at once.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q      <= ARB_IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      rr_ptr_q     <= MIDX_W'(MASTER_NUM - 1);
      beats_left_q <= '0;
      data_owner_q <= '0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      beats_left_q <= beats_left_d;
      data_owner_q <= data_owner_d;
      data_valid_q <= data_valid_d;
    end
  end

  // Next-state: ownership decisions and data-phase capture, only when hready.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    beats_left_d = beats_left_q;
    data_owner_d = data_owner_q;
    data_valid_d = data_valid_q;
    rearb        = 1'b0;

    if (hready) begin
      // The address phase accepted this cycle becomes next cycle's data phase.
      data_owner_d = owner_q;
      data_valid_d = hsel && own_addr;

      unique case (state_q)
        ARB_IDLE: rearb = 1'b1;
        ARB_OWN: begin
          if (own_req && (own_trans == NONSEQ) && (own_len > 5'd1)) begin
            // First beat of a fixed burst is accepted now.
            state_d      = ARB_BURST;
            beats_left_d = BEATS_W'(own_len - 5'd1);
          end else if (!(own_req && ((own_trans == SEQ) || (own_trans == BUSY)))) begin
            rearb = 1'b1;
          end
        end
        ARB_BURST: begin
          if (!own_req || (own_trans == IDLE) || (own_trans == NONSEQ)) begin
            rearb = 1'b1;
          end else if (own_trans == SEQ) begin
            if (beats_left_q <= BEATS_W'(1)) rearb = 1'b1;
            else                             beats_left_d = beats_left_q - BEATS_W'(1);
          end
        end
        default: rearb = 1'b1;
      endcase

      if (rearb) begin
        beats_left_d = '0;
        if (pick_any) begin
          state_d  = ARB_OWN;
          grant_d  = pick_win;
          owner_d  = pick_idx;
          rr_ptr_d = pick_idx;
        end else begin
          state_d = ARB_IDLE;
          grant_d = '0;
        end
      end
    end
  end

  // Outputs: registered grant/owners, hsel qualified by the live request.
  always_comb begin
    hgrant      = grant_q;
    hsel        = |(grant_q & hreq);
    haddr_owner = owner_q;
    hdata_owner = data_owner_q;
    hdata_valid = data_valid_q;
  end

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Directed bench for ahb_slave_arbiter with 4 masters.
module tb_ahb_slave_arbiter;
  import ahb_slave_arbiter_pkg::*;

  logic       hclk;
  logic       hreset;
  logic [3:0] hreq;
  htrans_type trans [4];
  hburst_type burst [4];
  logic       hready;
  logic [3:0] hgrant;
  logic       hsel;
  logic [1:0] haddr_owner;
  logic [1:0] hdata_owner;
  logic       hdata_valid;

  int vectors;
  int miscompares;

  ahb_slave_arbiter #(.MASTER_NUM(4)) dut (
    .hclk        (hclk),
    .hreset      (hreset),
    .hreq        (hreq),
    .htrans      (trans),
    .hburst      (burst),
    .hready      (hready),
    .hgrant      (hgrant),
    .hsel        (hsel),
    .haddr_owner (haddr_owner),
    .hdata_owner (hdata_owner),
    .hdata_valid (hdata_valid)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic idle_all();
    hreq = 4'b0000;
    for (int m = 0; m < 4; m++) begin
      trans[m] = IDLE;
      burst[m] = SINGLE;
    end
  endtask

  task automatic do_reset();
    idle_all();
    hready = 1'b1;
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
  endtask

  task automatic test_reset();
    idle_all();
    hready = 1'b1;
    hreset = 1'b1;
    tick();
    tick();
    vectors++;
    if (hgrant !== 4'b0000) begin miscompares++; $display("FAIL reset_hgrant got %b want 0000", hgrant); end
    vectors++;
    if (hsel !== 1'b0) begin miscompares++; $display("FAIL reset_hsel got %b want 0", hsel); end
    vectors++;
    if (haddr_owner !== 2'd0 || hdata_owner !== 2'd0) begin
      miscompares++; $display("FAIL reset_owners got %0d/%0d want 0/0", haddr_owner, hdata_owner);
    end
    vectors++;
    if (hdata_valid !== 1'b0) begin miscompares++; $display("FAIL reset_hdata_valid got %b want 0", hdata_valid); end
    vectors++;
    if (dut.beats_left_q !== 4'd0) begin miscompares++; $display("FAIL reset_beats got %0d want 0", dut.beats_left_q); end
    hreset = 1'b0;
  endtask

  task automatic test_single_grant();
    do_reset();
    hreq = 4'b0100; trans[2] = NONSEQ; burst[2] = SINGLE;
    tick();
    vectors++;
    if (hgrant !== 4'b0100 || haddr_owner !== 2'd2) begin
      miscompares++; $display("FAIL single_grant got %b/%0d want 0100/2", hgrant, haddr_owner);
    end
    vectors++;
    if (hsel !== 1'b1 || hdata_valid !== 1'b0) begin
      miscompares++; $display("FAIL single_sel got hsel=%b dv=%b want 1/0", hsel, hdata_valid);
    end
    tick();
    vectors++;
    if (hdata_owner !== 2'd2 || hdata_valid !== 1'b1) begin
      miscompares++; $display("FAIL single_data got %0d/%b want 2/1", hdata_owner, hdata_valid);
    end
    idle_all();
    tick();
    vectors++;
    if (hgrant !== 4'b0000 || hdata_valid !== 1'b0) begin
      miscompares++; $display("FAIL single_release got %b/%b want 0000/0", hgrant, hdata_valid);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_g [6];
    logic [1:0] exp_o [6];
    exp_g = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
    exp_o = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
    do_reset();
    hreq = 4'b1011;
    trans[0] = NONSEQ; trans[1] = NONSEQ; trans[3] = NONSEQ;
    for (int k = 0; k < 6; k++) begin
      tick();
      vectors++;
      if (hgrant !== exp_g[k] || haddr_owner !== exp_o[k]) begin
        miscompares++;
        $display("FAIL rotation[%0d] got %b/%0d want %b/%0d", k, hgrant, haddr_owner, exp_g[k], exp_o[k]);
      end
      if (k > 0) begin
        vectors++;
        if (hdata_owner !== exp_o[k-1] || hdata_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL rotation_data[%0d] got %0d/%b want %0d/1", k, hdata_owner, hdata_valid, exp_o[k-1]);
        end
      end
    end
  endtask

  task automatic test_fixed_burst();
    htrans_type t_tab [12];
    logic       r_tab [12];
    logic [3:0] b_tab [12];
    t_tab = '{SEQ, BUSY, SEQ, SEQ, SEQ, BUSY, SEQ, SEQ, SEQ, SEQ, SEQ, SEQ};
    r_tab = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    b_tab = '{4'd6, 4'd6, 4'd6, 4'd5, 4'd4, 4'd4, 4'd4, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    do_reset();
    hreq = 4'b0010; trans[1] = NONSEQ; burst[1] = INCR8;
    tick();
    vectors++;
    if (hgrant !== 4'b0010) begin miscompares++; $display("FAIL incr8_grant got %b want 0010", hgrant); end
    hreq = 4'b0011; trans[0] = NONSEQ; burst[0] = SINGLE;
    tick();
    vectors++;
    if (hgrant !== 4'b0010 || dut.beats_left_q !== 4'd7) begin
      miscompares++; $display("FAIL incr8_start got %b/%0d want 0010/7", hgrant, dut.beats_left_q);
    end
    for (int i = 0; i < 12; i++) begin
      trans[1] = t_tab[i];
      hready   = r_tab[i];
      tick();
      vectors++;
      if (i < 11) begin
        if (hgrant !== 4'b0010 || dut.beats_left_q !== b_tab[i]) begin
          miscompares++;
          $display("FAIL incr8_hold[%0d] got %b/%0d want 0010/%0d", i, hgrant, dut.beats_left_q, b_tab[i]);
        end
      end else begin
        if (hgrant !== 4'b0001 || haddr_owner !== 2'd0 || dut.beats_left_q !== b_tab[i]) begin
          miscompares++;
          $display("FAIL incr8_handover got %b/%0d/%0d want 0001/0/0", hgrant, haddr_owner, dut.beats_left_q);
        end
      end
    end
    vectors++;
    if (hdata_owner !== 2'd1 || hdata_valid !== 1'b1) begin
      miscompares++; $display("FAIL incr8_last_data got %0d/%b want 1/1", hdata_owner, hdata_valid);
    end
    hready = 1'b1;
  endtask

  task automatic test_early_term();
    do_reset();
    hreq = 4'b1000; trans[3] = NONSEQ; burst[3] = INCR4;
    tick();
    hreq = 4'b1001; trans[0] = NONSEQ;
    tick();
    vectors++;
    if (hgrant !== 4'b1000 || dut.beats_left_q !== 4'd3) begin
      miscompares++; $display("FAIL incr4_start got %b/%0d want 1000/3", hgrant, dut.beats_left_q);
    end
    trans[3] = SEQ;
    tick();
    trans[3] = IDLE;
    tick();
    vectors++;
    if (hgrant !== 4'b0001 || haddr_owner !== 2'd0 || dut.beats_left_q !== 4'd0) begin
      miscompares++;
      $display("FAIL incr4_early got %b/%0d/%0d want 0001/0/0", hgrant, haddr_owner, dut.beats_left_q);
    end
  endtask

  task automatic test_reset_midburst();
    do_reset();
    hreq = 4'b0100; trans[2] = NONSEQ; burst[2] = WRAP16;
    tick();
    tick();
    trans[2] = SEQ;
    tick();
    vectors++;
    if (hgrant !== 4'b0100 || hdata_valid !== 1'b1 || dut.beats_left_q !== 4'd14) begin
      miscompares++;
      $display("FAIL wrap16_pre got %b/%b/%0d want 0100/1/14", hgrant, hdata_valid, dut.beats_left_q);
    end
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
    vectors++;
    if (hgrant !== 4'b0000 || hsel !== 1'b0 || haddr_owner !== 2'd0 ||
        hdata_owner !== 2'd0 || hdata_valid !== 1'b0 || dut.beats_left_q !== 4'd0) begin
      miscompares++;
      $display("FAIL wrap16_reset got g=%b s=%b ao=%0d do=%0d dv=%b bl=%0d want all 0",
               hgrant, hsel, haddr_owner, hdata_owner, hdata_valid, dut.beats_left_q);
    end
    idle_all();
    hreq = 4'b0010; trans[1] = NONSEQ;
    tick();
    vectors++;
    if (hgrant !== 4'b0010 || haddr_owner !== 2'd1) begin
      miscompares++; $display("FAIL post_reset_grant got %b/%0d want 0010/1", hgrant, haddr_owner);
    end
  endtask

  task automatic test_incr_undefined();
    do_reset();
    hreq = 4'b0001; trans[0] = NONSEQ; burst[0] = INCR;
    tick();
    tick();
    vectors++;
    if (hgrant !== 4'b0001) begin miscompares++; $display("FAIL incr_start got %b want 0001", hgrant); end
    hreq = 4'b0101; trans[2] = NONSEQ; trans[0] = SEQ;
    for (int i = 0; i < 20; i++) begin
      tick();
      vectors++;
      if (hgrant !== 4'b0001 || hdata_owner !== 2'd0) begin
        miscompares++; $display("FAIL incr_hold[%0d] got %b/%0d want 0001/0", i, hgrant, hdata_owner);
      end
    end
    hreq = 4'b0100; trans[0] = IDLE;
    tick();
    vectors++;
    if (hgrant !== 4'b0100 || haddr_owner !== 2'd2 || hdata_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL incr_release got %b/%0d/%b want 0100/2/0", hgrant, haddr_owner, hdata_valid);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    idle_all();
    hready = 1'b1;
    hreset = 1'b1;
    test_reset();
    test_single_grant();
    test_rotation();
    test_fixed_burst();
    test_early_term();
    test_reset_midburst();
    test_incr_undefined();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ahb_slave_arbiter.md
# ahb_slave_arbiter

Per-slave arbiter sitting directly downstream of the per-master AHB address decoders. Each decoder raises its `hreq` bit for this slave. The arbiter collects the matching bit from every master and grants the slave port to one master at a time, using round-robin priority. It keeps ownership through fixed-length bursts and undefined-length INCR bursts, and tracks which master owns the data phase so the interconnect can steer write data and read/response muxes.

## Interface
Parameters:
- `MASTER_NUM`, default 4: number of masters contending for this slave (≥2).
- `MIDX_W`, default `$clog2(MASTER_NUM)`: master index width.

Ports:
- `hclk`, in, 1: single clock.
- `hreset`, in, 1: synchronous, active-high reset.
- `hreq`, in, `MASTER_NUM`: bit m is master m's decoder `hreq` bit for this slave.
- `htrans`, in, `MASTER_NUM` × `htrans_type`: per-master transfer type.
- `hburst`, in, `MASTER_NUM` × `hburst_type`: per-master burst type.
- `hready`, in, 1: selected slave's `hreadyout`.
- `hgrant`, out, `MASTER_NUM`: one-hot address-phase grant, or all-zero.
- `hsel`, out, 1: slave select; equals `|(hgrant & hreq)`.
- `haddr_owner`, out, `MIDX_W`: index of the address-phase owner.
- `hdata_owner`, out, `MIDX_W`: index of the data-phase owner.
- `hdata_valid`, out, 1: a data phase to this slave is in progress.

## Operation
- FSM states:
  - `ARB_IDLE`: no owner.
  - `ARB_OWN`: owner holds the port with single or INCR transfers.
  - `ARB_BURST`: owner is in a fixed-length burst.
- All state updates occur only on cycles with `hready`=1. With `hready`=0 everything holds.
- Round-robin arbitration:
  - Winner is the first master m with `hreq[m]`=1, searching from `rr_ptr`+1 upward and wrapping modulo `MASTER_NUM`.
  - On every grant change, `rr_ptr` is set to the winner.
  - If no request is present: go to `ARB_IDLE` and set `hgrant`=0.
- `ARB_IDLE`: arbitrate; on any request, go to `ARB_OWN` with the winner.
- `ARB_OWN`, owner o:
  - o issues NONSEQ with `hburst` in {INCR4, WRAP4, INCR8, WRAP8, INCR16, WRAP16}: go to `ARB_BURST`, `beats_left` = length−1, grant held.
  - o issues SEQ or BUSY (INCR continuation): hold grant.
  - o issues IDLE, or NONSEQ with SINGLE/INCR, or drops `hreq`: re-arbitrate. o can win again only if no other master is requesting.
- `ARB_BURST`:
  - Each SEQ beat accepted decrements `beats_left`; BUSY does not.
  - On an accepted SEQ beat with `beats_left`=1: re-arbitrate, leave `ARB_BURST`.
  - Early termination (owner IDLE, NONSEQ, or `hreq`=0): re-arbitrate immediately, and `beats_left` is cleared.
- `beats_left` is 4 bits and saturates at 0; it never underflows.
- Data-phase tracking: on `hready`=1, `hdata_owner` ← `haddr_owner` and `hdata_valid` ← `hsel` & (owner `htrans` ∈ {NONSEQ, SEQ}).
- Reset values:
  - `hgrant`=0, `hsel`=0, `haddr_owner`=0, `hdata_owner`=0, `hdata_valid`=0.
  - State `ARB_IDLE`, `beats_left`=0.
  - `rr_ptr`=`MASTER_NUM`−1, so master 0 wins first.
- A reset asserted mid-burst aborts ownership immediately on the next edge. No pending state survives.

## Timing
- `hgrant`, `haddr_owner`, `hdata_owner` and `hdata_valid` are registered. `hsel` is combinational from registered `hgrant` and the live `hreq`.
- Grant latency: a request sampled at edge N with `hready`=1 gives `hgrant` at N+1.
- Handover: after the last accepted beat at edge N, the new owner's grant is visible at N+1. The old owner's data phase completes under `hdata_owner` during N+1 (pipelined overlap).
- The data-phase owner lags the address-phase owner by exactly one `hready`-qualified cycle.
- Simultaneous requests: resolved purely by `rr_ptr`. A new request in the same cycle as the owner releases competes normally.

## Structure
- `AHB_package` holds:
  - `htrans_type`, already defined.
  - `hburst_type` {SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16}.
  - The function `burst_len(hburst_type)` returning 1/4/8/16, with 0 for INCR.
- Sub-module `ahb_rr_picker`: combinational round-robin search. Inputs are `req` and `ptr`; outputs are a one-hot `win` and its index.
- The FSM, counter and data-phase registers live in the top module.

## Test plan
- Reset, then master 2 raises `hreq`, NONSEQ SINGLE, `hready`=1 → `hgrant`=4'b0100 one cycle later, `haddr_owner`=2; next cycle `hdata_owner`=2, `hdata_valid`=1.
- Masters 0, 1 and 3 request continuously with SINGLE transfers → grants rotate 0, 1, 3, 0, 1, 3 on successive cycles.
- Master 1 INCR8 (NONSEQ + 7 SEQ) with master 0 requesting, 2 BUSY cycles and 3 cycles of `hready`=0 inserted → grant stays on 1 for all 8 beats; master 0 is granted the cycle after the 8th beat is accepted.
- Master 3 INCR4 terminated with IDLE after 2 beats while master 0 requests → grant moves to 0 next cycle, `beats_left`=0.
- `hreset` asserted at beat 3 of a WRAP16 → all outputs 0 next edge; the next lone request from master 1 is granted one cycle later.
- Undefined-length INCR from master 0 for 20 SEQ beats, master 2 requesting → master 0 held for all beats; master 2 is granted after master 0's IDLE.
